// File: rtl/counter_ctrl.sv
// counter_ctrl: synchronizes and debounces four push-buttons and sequences the
// clear/run/hold level controls of the up/down counter. Optional macro: PAUSE_TIMEOUT_EN.
module counter_ctrl #(
  parameter int unsigned DEB_CNT   = 50000,
  parameter int unsigned DEB_W     = 16,
  parameter int unsigned CLR_LEN   = 2,
  parameter int unsigned PAUSE_MAX = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_clear_raw,
  input  logic       btn_pause_raw,
  input  logic       btn_mode_raw,
  input  logic       btn_dir_raw,
  output logic       clear,
  output logic       pause,
  output logic       mode,
  output logic       incr,
  output logic [1:0] state
);

  localparam int unsigned NBTN    = 4;
  localparam int unsigned B_CLR   = 0;
  localparam int unsigned B_PAUSE = 1;
  localparam int unsigned B_MODE  = 2;
  localparam int unsigned B_DIR   = 3;
  localparam int unsigned CLR_W   = (CLR_LEN > 1) ? $clog2(CLR_LEN) : 1;

  typedef enum logic [1:0] {
    ST_CLR  = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] ev;

  assign btn_raw = {btn_dir_raw, btn_mode_raw, btn_pause_raw, btn_clear_raw};

  // Per-button synchronizer, debouncer and registered rising-edge pulse
  for (genvar g = 0; g < NBTN; g++) begin : g_btn
    logic             s1_q;
    logic             s2_q;
    logic             deb_q;
    logic             deb_d;
    logic             deb_dly_q;
    logic             ev_q;
    logic [DEB_W-1:0] cnt_q;
    logic [DEB_W-1:0] cnt_d;

    always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (s2_q != deb_q) begin
        if (cnt_q == DEB_W'(DEB_CNT - 1)) begin
          deb_d = s2_q;
        end else begin
          cnt_d = cnt_q + DEB_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_q      <= 1'b0;
        s2_q      <= 1'b0;
        deb_q     <= 1'b0;
        deb_dly_q <= 1'b0;
        ev_q      <= 1'b0;
        cnt_q     <= '0;
      end else begin
        s1_q      <= btn_raw[g];
        s2_q      <= s1_q;
        deb_q     <= deb_d;
        deb_dly_q <= deb_q;
        ev_q      <= deb_q & ~deb_dly_q;
        cnt_q     <= cnt_d;
      end
    end

    assign ev[g] = ev_q;
  end

  logic clr_ev;
  logic pause_ev;
  logic mode_ev;
  logic dir_ev;

  assign clr_ev   = ev[B_CLR];
  assign pause_ev = ev[B_PAUSE];
  assign mode_ev  = ev[B_MODE];
  assign dir_ev   = ev[B_DIR];

  state_e           state_q;
  state_e           state_d;
  logic [CLR_W-1:0] clr_cnt_q;
  logic [CLR_W-1:0] clr_cnt_d;
  logic             clear_q;
  logic             clear_d;
  logic             pause_q;
  logic             pause_d;
  logic             mode_q;
  logic             mode_d;
  logic             incr_q;
  logic             incr_d;

`ifdef PAUSE_TIMEOUT_EN
  localparam int unsigned TO_W = (PAUSE_MAX > 1) ? $clog2(PAUSE_MAX) : 1;

  logic [TO_W-1:0] to_cnt_q;
  logic [TO_W-1:0] to_cnt_d;
  logic            to_expired;

  assign to_expired = (to_cnt_q == TO_W'(PAUSE_MAX - 1));

  // Idle-cycle count while remaining in HOLD; any exit (event or expiry) restarts it
  always_comb begin
    to_cnt_d = '0;
    if ((state_q == ST_HOLD) && (state_d == ST_HOLD)) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`endif

  // State register; outputs are registered from their next-state values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLR;
      clr_cnt_q <= '0;
      clear_q   <= 1'b1;
      pause_q   <= 1'b0;
      mode_q    <= 1'b0;
      incr_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      clear_q   <= clear_d;
      pause_q   <= pause_d;
      mode_q    <= mode_d;
      incr_q    <= incr_d;
    end
  end

  // Next-state logic; clear always wins over a simultaneous pause event
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      ST_CLR: begin
        if (clr_ev) begin
          clr_cnt_d = '0;
        end else if (clr_cnt_q == CLR_W'(CLR_LEN - 1)) begin
          state_d   = ST_RUN;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + CLR_W'(1);
        end
      end
      ST_RUN: begin
        if (clr_ev) begin
          state_d   = ST_CLR;
          clr_cnt_d = '0;
        end else if (pause_ev) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (clr_ev) begin
          state_d   = ST_CLR;
          clr_cnt_d = '0;
        end else if (pause_ev) begin
          state_d = ST_RUN;
`ifdef PAUSE_TIMEOUT_EN
        end else if (to_expired) begin
          state_d = ST_RUN;
`endif
        end
      end
      default: begin
        state_d   = ST_CLR;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Output decode from next state; mode/incr toggle independently of the FSM
  always_comb begin
    clear_d = (state_d == ST_CLR);
    pause_d = (state_d == ST_HOLD);
    mode_d  = mode_q ^ mode_ev;
    incr_d  = incr_q ^ dir_ev;
  end

  assign clear = clear_q;
  assign pause = pause_q;
  assign mode  = mode_q;
  assign incr  = incr_q;
  assign state = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: directed scenarios plus random button
// traffic, compared every cycle against a cycle-count based behavioural model.
module tb_counter_ctrl;

  localparam int unsigned DEB_CNT   = 4;
  localparam int unsigned DEB_W     = 4;
  localparam int unsigned CLR_LEN   = 2;
  localparam int unsigned PAUSE_MAX = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       bc = 1'b0;
  logic       bp = 1'b0;
  logic       bm = 1'b0;
  logic       bd = 1'b0;
  logic       clear;
  logic       pause;
  logic       mode;
  logic       incr;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_ctrl #(
    .DEB_CNT  (DEB_CNT),
    .DEB_W    (DEB_W),
    .CLR_LEN  (CLR_LEN),
    .PAUSE_MAX(PAUSE_MAX)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_clear_raw(bc),
    .btn_pause_raw(bp),
    .btn_mode_raw (bm),
    .btn_dir_raw  (bd),
    .clear        (clear),
    .pause        (pause),
    .mode         (mode),
    .incr         (incr),
    .state        (state)
  );

  // Model: state as 0=CLR 1=RUN 2=HOLD, remaining clear cycles, idle HOLD cycles
  int       m_state  = 0;
  int       clr_left = CLR_LEN;
  int       hold_cnt = 0;
  bit       m_mode   = 1'b0;
  bit       m_incr   = 1'b1;
  bit       m_deb [4];
  int       m_run [4];
  bit [3:0] pipe  [4];

  // A press counts once DEB_CNT consecutive samples differ from the debounced
  // level; its effect reaches the outputs 4 edges after the last such sample.
  task automatic model_step(input logic rstv, input logic [3:0] raw);
    bit [3:0] fire;
    if (!rstv) begin
      m_state  = 0;
      clr_left = CLR_LEN;
      hold_cnt = 0;
      m_mode   = 1'b0;
      m_incr   = 1'b1;
      for (int b = 0; b < 4; b++) begin
        m_deb[b] = 1'b0;
        m_run[b] = 0;
        pipe[b]  = '0;
      end
      return;
    end
    for (int b = 0; b < 4; b++) begin
      fire[b] = pipe[b][3];
      pipe[b] = pipe[b] << 1;
      if (raw[b] != m_deb[b]) begin
        m_run[b]++;
        if (m_run[b] == int'(DEB_CNT)) begin
          m_deb[b]   = raw[b];
          m_run[b]   = 0;
          pipe[b][0] = raw[b];
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_mode = m_mode ^ fire[2];
    m_incr = m_incr ^ fire[3];
    if (m_state == 0) begin
      if (fire[0]) clr_left = CLR_LEN;
      else begin
        clr_left--;
        if (clr_left == 0) m_state = 1;
      end
    end else if (m_state == 1) begin
      if (fire[0]) begin
        m_state  = 0;
        clr_left = CLR_LEN;
      end else if (fire[1]) begin
        m_state  = 2;
        hold_cnt = 0;
      end
    end else begin
      if (fire[0]) begin
        m_state  = 0;
        clr_left = CLR_LEN;
      end else if (fire[1]) begin
        m_state = 1;
      end else begin
        hold_cnt++;
`ifdef PAUSE_TIMEOUT_EN
        if (hold_cnt == int'(PAUSE_MAX)) m_state = 1;
`endif
      end
    end
  endtask

  // Per-cycle comparison of every output against the model
  initial begin
    logic [5:0] exp_v;
    logic [5:0] act_v;
    forever begin
      @(posedge clk);
      model_step(rst_n, {bd, bm, bp, bc});
      #1;
      exp_v = {2'(m_state), m_state == 0, m_state == 2, m_mode, m_incr};
      act_v = {state, clear, pause, mode, incr};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_model t=%0t {state,clear,pause,mode,incr} actual=%b required=%b",
                 $time, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pos(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold a set of buttons {dir,mode,pause,clear} for n cycles, then release and settle
  task automatic press(input logic [3:0] m, input int n);
    {bd, bm, bp, bc} = m;
    wait_neg(n);
    {bd, bm, bp, bc} = 4'b0000;
    wait_neg(12);
  endtask

  int hold_left [4];

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("reset_vals", 8'({state, clear, pause, mode, incr}), 8'b00_1_0_0_1);
    wait_neg(3);
    rst_n = 1'b1;

    // Clear phase after reset release
    wait_pos(1);
    chk("clr_phase_1", 8'({state, clear}), 8'b00_1);
    wait_pos(1);
    chk("run_after_clr", 8'({state, clear, pause, mode, incr}), 8'b01_0_0_0_1);
    wait_neg(3);

    // Short glitch is filtered
    press(4'b0010, 3);
    chk("glitch_ignored", 8'({state, pause}), 8'b01_0);

    // Exact press-to-output latency
    @(negedge clk);
    bp = 1'b1;
    wait_pos(7);
    chk("latency_before", 8'({state, pause}), 8'b01_0);
    wait_pos(1);
    chk("latency_at", 8'({state, pause}), 8'b10_1);
    @(negedge clk);
    wait_neg(2);
    bp = 1'b0;
    wait_neg(12);
    chk("hold_kept", 8'(state), 8'd2);
    press(4'b0010, 10);
    chk("resume_run", 8'({state, pause}), 8'b01_0);

    // Clear and pause together from HOLD: clear wins
    press(4'b0010, 10);
    chk("hold_again", 8'(state), 8'd2);
    {bc, bp} = 2'b11;
    wait_pos(8);
    chk("clr_wins", 8'({state, clear, pause}), 8'b00_1_0);
    wait_pos(1);
    chk("clr_wins_2", 8'({state, clear, pause}), 8'b00_1_0);
    wait_pos(1);
    chk("clr_to_run", 8'({state, clear, pause}), 8'b01_0_0);
    @(negedge clk);
    {bc, bp} = 2'b00;
    wait_neg(12);
    chk("pause_discarded", 8'(state), 8'd1);

    // Mode and direction toggles survive a clear
    press(4'b0100, 10);
    chk("mode_toggle", 8'({mode, incr}), 8'b1_1);
    press(4'b1000, 10);
    chk("dir_toggle_1", 8'({mode, incr}), 8'b1_0);
    press(4'b1000, 10);
    chk("dir_toggle_2", 8'({mode, incr}), 8'b1_1);
    press(4'b0001, 10);
    chk("clr_keeps_mode", 8'({state, mode, incr}), 8'b01_1_1);

    // Bouncy long press yields one event, then reset mid-HOLD
    for (int i = 0; i < 200; i++) begin
      bp = (i < 12) ? (((i / 2) % 2) == 0) : 1'b1;
      @(negedge clk);
    end
    bp = 1'b0;
    wait_neg(12);
    chk("bounce_one_event", 8'({state, pause}), 8'b10_1);
    rst_n = 1'b0;
    #1;
    chk("async_reset", 8'({state, clear, pause, mode, incr}), 8'b00_1_0_0_1);
    wait_neg(3);
    rst_n = 1'b1;
    wait_neg(6);
    chk("run_after_reset", 8'(state), 8'd1);

    // HOLD timeout behaviour
    bp = 1'b1;
    wait_pos(8);
    chk("hold_entry", 8'(state), 8'd2);
`ifdef PAUSE_TIMEOUT_EN
    wait_pos(int'(PAUSE_MAX) - 1);
    chk("hold_before_to", 8'(state), 8'd2);
    wait_pos(1);
    chk("timeout_run", 8'({state, pause}), 8'b01_0);
    @(negedge clk);
    bp = 1'b0;
    wait_neg(12);
`else
    @(negedge clk);
    bp = 1'b0;
    wait_neg(1000);
    chk("hold_no_timeout", 8'({state, pause}), 8'b10_1);
`endif

    // Random button traffic with occasional resets
    for (int b = 0; b < 4; b++) hold_left[b] = 0;
    for (int c = 0; c < 4000; c++) begin
      logic [3:0] lv;
      lv = {bd, bm, bp, bc};
      for (int b = 0; b < 4; b++) begin
        if (hold_left[b] == 0) begin
          lv[b]        = 1'($urandom_range(0, 1));
          hold_left[b] = int'($urandom_range(1, 12));
        end else begin
          hold_left[b]--;
        end
      end
      {bd, bm, bp, bc} = lv;
      rst_n = ($urandom_range(0, 999) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    {bd, bm, bp, bc} = 4'b0000;
    wait_neg(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
